// File: rtl/note_pkg.sv
// Shared note-period table and decoder defaults, common to the buzzer melody player
// and the tone note decoder.
package note_pkg;

  localparam int unsigned CNT_W_DEF     = 17;
  localparam int unsigned DUR_W_DEF     = 11;
  localparam int unsigned TOL_SHIFT_DEF = 6;
  localparam int unsigned LOCK_CNT_DEF  = 4;
  localparam int unsigned NUM_NOTES     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StLocked
  } state_e;

  // Tone period in clk cycles for note M<idx>.
  function automatic int unsigned note_period(input logic [2:0] idx);
    case (idx)
      3'd0:    return 98800;
      3'd1:    return 95600;
      3'd2:    return 85150;
      3'd3:    return 75850;
      3'd4:    return 71600;
      3'd5:    return 63750;
      3'd6:    return 56800;
      3'd7:    return 50600;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/tone_period_classifier.sv
// Combinational window match of a measured period against the note table; the lowest
// matching index wins.
module tone_period_classifier
  import note_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned TOL_SHIFT    = TOL_SHIFT_DEF,
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input  logic [CNT_W-1:0] period_i,
  output logic             hit_o,
  output logic [2:0]       idx_o
);

  logic [31:0] per;
  logic [31:0] ref_p;
  logic [31:0] tol;
  logic [31:0] diff;

  assign per = 32'(period_i);

  // Walk from the top so a lower index overwrites any higher match.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 3'd0;
    ref_p = '0;
    tol   = '0;
    diff  = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      ref_p = note_period(3'(i)) >> PERIOD_SHIFT;
      tol   = ref_p >> TOL_SHIFT;
      diff  = (per >= ref_p) ? (per - ref_p) : (ref_p - per);
      if (diff <= tol) begin
        hit_o = 1'b1;
        idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tone_note_decoder.sv
// Measures the period of a square-wave tone and decodes it to notes M0..M7 with durations.
// Define TONE_DEGLITCH_EN to reject input pulses of 3 cycles or less (edge latency 6 clk).
module tone_note_decoder
  import note_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DUR_W        = DUR_W_DEF,
  parameter int unsigned TOL_SHIFT    = TOL_SHIFT_DEF,
  parameter int unsigned LOCK_CNT     = LOCK_CNT_DEF,
  // Divides the note table; 0 for real tones, nonzero only for scaled-down runs.
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             period_vld,
  output logic [CNT_W-1:0] period_out,
  output logic             note_on,
  output logic [2:0]       note_code,
  output logic             note_start,
  output logic             note_end,
  output logic [DUR_W-1:0] note_dur
);

  localparam int unsigned MCNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0] sync_q;
  logic       tone_s;
  logic       rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], tone_in};
  end
  assign tone_s = sync_q[1];

`ifdef TONE_DEGLITCH_EN
  logic [3:0] hist_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= {hist_q[2:0], tone_s};
  end
  // One low sample followed by four consecutive highs.
  assign rise = ({hist_q, tone_s} == 5'b01111);
`else
  logic prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= tone_s;
  end
  assign rise = tone_s & ~prev_q;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          cand_q, cand_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [MCNT_W-1:0]   mcnt_nxt;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                vld_q, vld_d;
  logic [CNT_W-1:0]    per_q, per_d;
  logic [2:0]          code_q, code_d;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic [DUR_W-1:0]    ndur_q, ndur_d;

  logic [CNT_W-1:0]    meas_period;
  logic                cls_hit;
  logic [2:0]          cls_idx;
  logic                match;
  logic                timeout;

  assign meas_period = (cnt_q == CntMax) ? CntMax : cnt_q + CNT_W'(1);

  tone_period_classifier #(
    .CNT_W       (CNT_W),
    .TOL_SHIFT   (TOL_SHIFT),
    .PERIOD_SHIFT(PERIOD_SHIFT)
  ) u_classifier (
    .period_i(meas_period),
    .hit_o   (cls_hit),
    .idx_o   (cls_idx)
  );

  // A period ending on a saturated counter is never a note.
  assign match   = cls_hit & (cnt_q != CntMax);
  // Fires on the clock that brings the counter to saturation.
  assign timeout = (cnt_q == CntMax - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    cand_d   = cand_q;
    mcnt_d   = mcnt_q;
    mcnt_nxt = '0;
    dur_d    = dur_q;
    vld_d    = 1'b0;
    per_d    = per_q;
    code_d   = code_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    ndur_d   = ndur_q;

    if (rise) begin
      cnt_d = '0;
      if (state_q == StIdle) begin
        state_d = StAcq;
        cand_d  = 3'd0;
        mcnt_d  = '0;
      end else begin
        vld_d = 1'b1;
        per_d = meas_period;
        case (state_q)
          StAcq: begin
            if (match) begin
              mcnt_nxt = (cls_idx == cand_q) ? mcnt_q + MCNT_W'(1) : MCNT_W'(1);
              cand_d   = cls_idx;
              if (mcnt_nxt == MCNT_W'(LOCK_CNT)) begin
                state_d = StLocked;
                mcnt_d  = '0;
                code_d  = cls_idx;
                start_d = 1'b1;
                dur_d   = DUR_W'(LOCK_CNT);
              end else begin
                mcnt_d = mcnt_nxt;
              end
            end else begin
              mcnt_d = '0;
            end
          end
          StLocked: begin
            if (match && cls_idx == code_q) begin
              dur_d = (dur_q == '1) ? dur_q : dur_q + DUR_W'(1);
            end else begin
              end_d   = 1'b1;
              ndur_d  = dur_q;
              state_d = StAcq;
              if (match) begin
                cand_d = cls_idx;
                mcnt_d = MCNT_W'(1);
              end else begin
                mcnt_d = '0;
              end
            end
          end
          default: ;
        endcase
      end
    end else if (timeout) begin
      state_d = StIdle;
      if (state_q == StLocked) begin
        end_d  = 1'b1;
        ndur_d = dur_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
      mcnt_q  <= '0;
      dur_q   <= '0;
      vld_q   <= 1'b0;
      per_q   <= '0;
      code_q  <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      ndur_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      mcnt_q  <= mcnt_d;
      dur_q   <= dur_d;
      vld_q   <= vld_d;
      per_q   <= per_d;
      code_q  <= code_d;
      start_q <= start_d;
      end_q   <= end_d;
      ndur_q  <= ndur_d;
    end
  end

  assign period_vld = vld_q;
  assign period_out = per_q;
  assign note_on    = (state_q == StLocked);
  assign note_code  = code_q;
  assign note_start = start_q;
  assign note_end   = end_q;
  assign note_dur   = ndur_q;

endmodule
